glyph_pixel_fetch: RTL and testbench
====================================

// Module: glyph_pixel_fetch
// PURPOSE
//  Parametrised glyph-pixel fetch unit for the VGA text/sprite path: takes (glyph index, x, y, flip) requests,
//  computes the flat glyph-memory address, reads a synchronous ROM and returns one pixel per accepted request.
//  Adds valid/ready flow control, H/V mirroring and out-of-range detection. Sits between the character/tile
//  scanner and the pixel mux in the VGA pipeline.
// PARAMETERS
//  PIXEL_W     24            bits per pixel word (RGB888 default)
//  GLYPH_W     16            glyph width in pixels
//  GLYPH_H     16            glyph height in pixels
//  NUM_GLYPHS  256           glyphs stored; ROM depth = NUM_GLYPHS*GLYPH_W*GLYPH_H
//  INIT_FILE   "glyph.txt"   $readmemh image, glyph-major, row-major within a glyph
//  TRANSP_KEY  24'hFF00FF    colour key, used only with GLYPH_TRANSPARENCY_EN
// PORTS
//  clk              in   1                 system clock; all logic on posedge
//  rst              in   1                 synchronous, active-high reset
//  req_valid        in   1                 request present
//  req_ready        out  1                 unit accepts request this cycle
//  req_glyph        in   IDX_W             glyph index, IDX_W=$clog2(NUM_GLYPHS) (min 1)
//  req_x            in   X_W               column in glyph, X_W=$clog2(GLYPH_W) (min 1)
//  req_y            in   Y_W               row in glyph, Y_W=$clog2(GLYPH_H) (min 1)
//  req_hflip        in   1                 mirror horizontally
//  req_vflip        in   1                 mirror vertically
//  pix_valid        out  1                 pixel result present
//  pix_ready        in   1                 consumer takes pixel this cycle
//  pix_data         out  PIXEL_W           pixel word
//  pix_oob          out  1                 request was out of range; pix_data forced 0
//  pix_transparent  out  1                 pixel equals TRANSP_KEY (only with GLYPH_TRANSPARENCY_EN)
// BEHAVIOUR
//  - Reset: pix_valid=0, pix_data=0, pix_oob=0, pix_transparent=0, all stage valids cleared; req_ready=1 the
//    cycle after rst deasserts. Reset mid-stream discards in-flight requests; no output for them.
//  - Handshake: transfer when valid&ready, on either side. Payload held stable while valid&~ready.
//  - Pipeline: S1 registers flipped coords + address + oob; S2 = ROM read. Accept at cycle N -> pix_valid at N+2.
//    Full throughput: one pixel per cycle with pix_ready held high.
//  - Stall: stall = pix_valid & ~pix_ready; req_ready = ~stall. On stall S1, ROM read enable and S2 hold;
//    ROM output must not change (read enable deasserted). No bubbles inserted, no data lost/duplicated.
//  - Flip: xe = hflip ? GLYPH_W-1-x : x; ye = vflip ? GLYPH_H-1-y : y (applied after range check).
//  - Address: req_glyph*GLYPH_W*GLYPH_H + ye*GLYPH_W + xe, width ADDR_W=$clog2(depth); products computed at
//    ADDR_W, no truncation for legal inputs.
//  - OOB: glyph>=NUM_GLYPHS or x>=GLYPH_W or y>=GLYPH_H (possible for non-power-of-2 sizes) -> address forced 0,
//    result pix_oob=1, pix_data=0, same latency as a legal request.
//  - Last glyph, last pixel (address depth-1) is legal; no wrap into glyph 0.
// CONFIGURATION
//  GLYPH_TRANSPARENCY_EN defined: pix_transparent = ~pix_oob & (pix_data==TRANSP_KEY), registered with pix_data,
//    reset 0, held during stall.
//  Not defined: pix_transparent port present, tied 0; no comparator synthesised.
// STRUCTURE
//  Package glyph_pkg: default PIXEL_W/GLYPH_W/GLYPH_H/NUM_GLYPHS, default TRANSP_KEY, clog2-min-1 width
//    helper function, ROM_DEPTH computation.
//  Sub-module glyph_rom_bank: single-port sync-read memory (addr, rd_en, dout registered on posedge clk,
//    $readmemh INIT_FILE, depth parameter); no reset on memory contents or dout.
//  Top: S1 regs, stall logic, OOB masking, optional key compare.
// TESTING
//  1 Load known image (word = address); req glyph=1,x=2,y=3, no flip, pix_ready=1 -> 2 cycles later
//    pix_data=256+48+2=306, pix_oob=0.
//  2 Same with hflip=1,vflip=1 -> address 256+12*16+13=461.
//  3 Stream 64 back-to-back requests, pix_ready low cycles 10-14 -> req_ready low those cycles, 64 outputs
//    in order, no drop/duplicate, pix_data stable while stalled.
//  4 NUM_GLYPHS=200: req_glyph=200 -> pix_oob=1, pix_data=0; req_glyph=199,x=15,y=15 -> last word, pix_oob=0.
//  5 Assert rst with 2 requests in flight -> next cycle pix_valid=0, no late outputs; post-reset request OK.
//  6 GLYPH_TRANSPARENCY_EN, word at target = 24'hFF00FF -> pix_transparent=1; 24'hFF00FE -> 0; macro off -> 0.

Source files
------------

// File: rtl/glyph_pkg.sv
// glyph_pkg
//   Shared defaults and sizing helpers for the glyph pixel fetch unit.
//   - DEF_* : default pixel width, glyph geometry, glyph count and colour key
//   - clog2_min1() : ceil(log2(n)), never below 1 so single-entry fields still get a bit
//   - rom_depth()  : total number of pixel words held in the glyph ROM
package glyph_pkg;

  localparam int          DEF_PIXEL_W    = 24;
  localparam int          DEF_GLYPH_W    = 16;
  localparam int          DEF_GLYPH_H    = 16;
  localparam int          DEF_NUM_GLYPHS = 256;
  localparam logic [23:0] DEF_TRANSP_KEY = 24'hFF00FF;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rom_depth(input int num_glyphs, input int glyph_w, input int glyph_h);
    return num_glyphs * glyph_w * glyph_h;
  endfunction

endpackage

// File: rtl/glyph_pixel_fetch_if.sv
// glyph_pixel_fetch_if
//   Request and pixel-result handshakes of the glyph pixel fetch unit.
//   Request side : req_valid/req_ready + glyph index, x, y, hflip, vflip
//   Result side  : pix_valid/pix_ready + pix_data, pix_oob, pix_transparent
//   modport master : the scanner/consumer (drives requests, accepts pixels)
//   modport slave  : the fetch unit
interface glyph_pixel_fetch_if #(
  parameter int IDX_W   = 8,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int PIXEL_W = 24
);

  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_glyph;
  logic [X_W-1:0]     req_x;
  logic [Y_W-1:0]     req_y;
  logic               req_hflip;
  logic               req_vflip;

  logic               pix_valid;
  logic               pix_ready;
  logic [PIXEL_W-1:0] pix_data;
  logic               pix_oob;
  logic               pix_transparent;

  modport master (
    output req_valid, req_glyph, req_x, req_y, req_hflip, req_vflip, pix_ready,
    input  req_ready, pix_valid, pix_data, pix_oob, pix_transparent
  );

  modport slave (
    input  req_valid, req_glyph, req_x, req_y, req_hflip, req_vflip, pix_ready,
    output req_ready, pix_valid, pix_data, pix_oob, pix_transparent
  );

endinterface

// File: rtl/glyph_rom_bank.sv
// glyph_rom_bank
//   Single-port synchronous-read glyph memory, glyph-major and row-major
//   within a glyph. Contents are loaded by the surrounding environment
//   (INIT_FILE names the image for the build flow). Neither contents nor
//   dout are reset.
//   clk   : clock
//   rd_en : when high, dout takes mem[addr] on the next posedge; otherwise dout holds
//   addr  : word address
//   dout  : registered read data
module glyph_rom_bank #(
  parameter int    DATA_W    = 24,
  parameter int    DEPTH     = 65536,
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rd_en) dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/glyph_pixel_fetch.sv
// glyph_pixel_fetch
//   Glyph pixel fetch unit for the VGA text/sprite path. Accepts (glyph, x, y,
//   hflip, vflip) requests, range-checks them, applies mirroring, forms the flat
//   ROM address and returns one pixel per accepted request two cycles later.
//   Stage S1 holds address + out-of-range flag, stage S2 is the ROM read.
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : synchronous active-high reset (clears all stage valids)
//     bus  : glyph_pixel_fetch_if.slave (request and pixel handshakes)
//   Optional feature: define GLYPH_TRANSPARENCY_EN to drive pix_transparent from a
//   compare of the fetched word against TRANSP_KEY; otherwise it is tied to 0.
module glyph_pixel_fetch
  import glyph_pkg::*;
#(
  parameter int                 PIXEL_W    = DEF_PIXEL_W,
  parameter int                 GLYPH_W    = DEF_GLYPH_W,
  parameter int                 GLYPH_H    = DEF_GLYPH_H,
  parameter int                 NUM_GLYPHS = DEF_NUM_GLYPHS,
  parameter string              INIT_FILE  = "glyph.txt",
  parameter logic [PIXEL_W-1:0] TRANSP_KEY = PIXEL_W'(DEF_TRANSP_KEY)
) (
  input  logic               clk,
  input  logic               rst,
  glyph_pixel_fetch_if.slave bus
);

  localparam int IDX_W      = clog2_min1(NUM_GLYPHS);
  localparam int X_W        = clog2_min1(GLYPH_W);
  localparam int Y_W        = clog2_min1(GLYPH_H);
  localparam int DEPTH      = rom_depth(NUM_GLYPHS, GLYPH_W, GLYPH_H);
  localparam int ADDR_W     = clog2_min1(DEPTH);
  localparam int GLYPH_SIZE = GLYPH_W * GLYPH_H;

  // Pipeline state
  logic              s1_valid_q,  s1_valid_d;
  logic              s1_oob_q,    s1_oob_d;
  logic [ADDR_W-1:0] s1_addr_q,   s1_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic              pix_oob_q,   pix_oob_d;

  // Request decode
  logic              stall;
  logic              accept;
  logic              req_oob;
  logic [X_W-1:0]    xe;
  logic [Y_W-1:0]    ye;
  logic [ADDR_W-1:0] addr_calc;
  logic [PIXEL_W-1:0] rom_dout;

  always_comb begin
    // The output register is the only place a result can wait, so a held
    // result freezes the whole pipe, including the ROM output register.
    stall  = pix_valid_q & ~bus.pix_ready;
    accept = bus.req_valid & ~stall;

    req_oob = (32'(bus.req_glyph) >= 32'(NUM_GLYPHS)) |
              (32'(bus.req_x)     >= 32'(GLYPH_W))    |
              (32'(bus.req_y)     >= 32'(GLYPH_H));

    // Mirroring is only meaningful for in-range coordinates; an out-of-range
    // request gets address 0 regardless of what the subtraction produces.
    xe = bus.req_hflip ? (X_W'(GLYPH_W - 1) - bus.req_x) : bus.req_x;
    ye = bus.req_vflip ? (Y_W'(GLYPH_H - 1) - bus.req_y) : bus.req_y;

    if (req_oob) begin
      addr_calc = '0;
    end else begin
      addr_calc = ADDR_W'(bus.req_glyph) * ADDR_W'(GLYPH_SIZE)
                + ADDR_W'(ye) * ADDR_W'(GLYPH_W)
                + ADDR_W'(xe);
    end

    // S1: load a new request (or a bubble) whenever the pipe moves
    s1_valid_d = stall ? s1_valid_q : accept;
    s1_oob_d   = stall ? s1_oob_q   : req_oob;
    s1_addr_d  = stall ? s1_addr_q  : addr_calc;

    // S2: status follows the ROM read that is enabled with ~stall
    pix_valid_d = stall ? pix_valid_q : s1_valid_q;
    pix_oob_d   = stall ? pix_oob_q   : s1_oob_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_oob_q    <= 1'b0;
      s1_addr_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_oob_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_oob_q    <= s1_oob_d;
      s1_addr_q   <= s1_addr_d;
      pix_valid_q <= pix_valid_d;
      pix_oob_q   <= pix_oob_d;
    end
  end

  glyph_rom_bank #(
    .DATA_W    (PIXEL_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk   (clk),
    .rd_en (~stall),
    .addr  (s1_addr_q),
    .dout  (rom_dout)
  );

  assign bus.req_ready = ~stall;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_oob   = pix_valid_q & pix_oob_q;
  // ROM dout is not reset, so the data path is masked until a valid in-range
  // result is present; this gives pix_data = 0 after reset and for OOB results.
  assign bus.pix_data  = (pix_valid_q & ~pix_oob_q) ? rom_dout : '0;

`ifdef GLYPH_TRANSPARENCY_EN
  assign bus.pix_transparent = pix_valid_q & ~pix_oob_q & (rom_dout == TRANSP_KEY);
`else
  logic unused_key_bits;
  assign unused_key_bits     = ^TRANSP_KEY;
  assign bus.pix_transparent = 1'b0;
`endif

endmodule

// File: tb/tb_glyph_pixel_fetch.sv
// tb_glyph_pixel_fetch
//   Self-checking bench for glyph_pixel_fetch (NUM_GLYPHS=200, 16x16 glyphs,
//   24-bit pixels). The ROM image is word = address, with two colour-key probe
//   words; expected pixels come from a reference function that applies the
//   range/flip/address rules directly to a bench-side copy of the image.
module tb_glyph_pixel_fetch;

  localparam int          PW    = 24;
  localparam int          GW    = 16;
  localparam int          GH    = 16;
  localparam int          NG    = 200;
  localparam int          DEPTH = NG * GW * GH;
  localparam logic [23:0] KEY   = 24'hFF00FF;
  localparam int          KEY_ADDR = 3 * 256 + 14 * 16 + 8;  // glyph 3, y 14, x 8

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glyph_pixel_fetch_if #(.IDX_W(8), .X_W(4), .Y_W(4), .PIXEL_W(PW)) bus ();

  glyph_pixel_fetch #(
    .PIXEL_W    (PW),
    .GLYPH_W    (GW),
    .GLYPH_H    (GH),
    .NUM_GLYPHS (NG),
    .INIT_FILE  (""),
    .TRANSP_KEY (KEY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        oob;
    logic        transp;
  } pix_t;

  logic [23:0] img [DEPTH];
  pix_t        exp_q [$];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passes++;
  endtask

  // Reference: pixel a request should produce, straight from the glyph rules.
  function automatic pix_t ref_pix(input int g, input int x, input int y, input bit hf, input bit vf);
    pix_t r;
    int   xe, ye;
    r = '0;
    if (g >= NG || x >= GW || y >= GH) begin
      r.oob = 1'b1;
      return r;
    end
    xe = hf ? (GW - 1 - x) : x;
    ye = vf ? (GH - 1 - y) : y;
    r.data = img[g * GW * GH + ye * GW + xe];
`ifdef GLYPH_TRANSPARENCY_EN
    r.transp = (r.data == KEY);
`endif
    return r;
  endfunction

  task automatic set_req(input int g, input int x, input int y, input bit hf, input bit vf);
    bus.req_glyph = 8'(g);
    bus.req_x     = 4'(x);
    bus.req_y     = 4'(y);
    bus.req_hflip = hf;
    bus.req_vflip = vf;
  endtask

  // One isolated request with exact latency checks; returns observed data.
  task automatic single(input string tag, input int g, input int x, input int y,
                        input bit hf, input bit vf, output logic [23:0] obs);
    pix_t e;
    e = ref_pix(g, x, y, hf, vf);
    @(posedge clk); #1;
    set_req(g, x, y, hf, vf);
    bus.req_valid = 1'b1;
    bus.pix_ready = 1'b1;
    #1;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    chk({tag, "_early_valid"}, 32'(bus.pix_valid), 32'd0);
    @(posedge clk); #2;
    chk({tag, "_valid"},  32'(bus.pix_valid),       32'd1);
    chk({tag, "_data"},   32'(bus.pix_data),        32'(e.data));
    chk({tag, "_oob"},    32'(bus.pix_oob),         32'(e.oob));
    chk({tag, "_transp"}, 32'(bus.pix_transparent), 32'(e.transp));
    obs = bus.pix_data;
    $display("%s: glyph=%0d x=%0d y=%0d hf=%0d vf=%0d -> data=0x%0h oob=%0d transp=%0d",
             tag, g, x, y, hf, vf, bus.pix_data, bus.pix_oob, bus.pix_transparent);
    @(posedge clk); #1;
  endtask

  // Stream of n requests; pix_ready forced low for cycles st_lo..st_hi.
  // rnd adds random request gaps and random consumer back-pressure.
  task automatic stream(input string tag, input int n, input int st_lo, input int st_hi, input bit rnd);
    int   sent, got, k;
    int   g, x, y;
    bit   hf, vf, stalled;
    pix_t e;
    sent = 0; got = 0; k = 0;
    exp_q.delete();
    g = $urandom_range(0, 255); x = $urandom_range(0, 15); y = $urandom_range(0, 15);
    hf = 1'($urandom_range(0, 1)); vf = 1'($urandom_range(0, 1));
    while ((sent < n || got < n) && k < 5000) begin
      @(posedge clk); #1;
      stalled       = (k >= st_lo) && (k <= st_hi);
      bus.req_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      set_req(g, x, y, hf, vf);
      bus.pix_ready = !stalled && (!rnd || $urandom_range(0, 3) != 0);
      #1;
      if (st_lo >= 0 && sent < n) chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(!stalled));
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_output"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"},   32'(bus.pix_data),        32'(e.data));
          chk({tag, "_oob"},    32'(bus.pix_oob),         32'(e.oob));
          chk({tag, "_transp"}, 32'(bus.pix_transparent), 32'(e.transp));
          $display("%s #%0d: data=0x%0h oob=%0d transp=%0d", tag, got,
                   bus.pix_data, bus.pix_oob, bus.pix_transparent);
          got++;
        end
      end else if (bus.pix_valid && exp_q.size() > 0) begin
        chk({tag, "_hold_data"}, 32'(bus.pix_data), 32'(exp_q[0].data));
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(ref_pix(g, x, y, hf, vf));
        sent++;
        g = $urandom_range(0, 255); x = $urandom_range(0, 15); y = $urandom_range(0, 15);
        hf = 1'($urandom_range(0, 1)); vf = 1'($urandom_range(0, 1));
      end
      k++;
    end
    chk({tag, "_sent"},  32'(sent), 32'(n));
    chk({tag, "_count"}, 32'(got),  32'(n));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      chk({tag, "_late_output"}, 32'(bus.pix_valid), 32'd0);
    end
  endtask

  initial begin
    logic [23:0] obs;
    bus.req_valid = 1'b0;
    bus.pix_ready = 1'b1;
    set_req(0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) img[i] = 24'(i);
    img[KEY_ADDR]     = KEY;
    img[KEY_ADDR + 1] = 24'hFF00FE;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = img[i];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_pix_valid",  32'(bus.pix_valid),       32'd0);
    chk("rst_pix_data",   32'(bus.pix_data),        32'd0);
    chk("rst_pix_oob",    32'(bus.pix_oob),         32'd0);
    chk("rst_pix_transp", 32'(bus.pix_transparent), 32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),       32'd1);

    single("basic", 1, 2, 3, 1'b0, 1'b0, obs);
    chk("basic_addr306", 32'(obs), 32'd306);
    single("flip", 1, 2, 3, 1'b1, 1'b1, obs);
    chk("flip_addr461", 32'(obs), 32'd461);
    single("oob_glyph", 200, 0, 0, 1'b0, 1'b0, obs);
    chk("oob_zero", 32'(obs), 32'd0);
    single("oob_glyph255", 255, 15, 15, 1'b1, 1'b0, obs);
    single("last_word", 199, 15, 15, 1'b0, 1'b0, obs);
    chk("last_word_val", 32'(obs), 32'(DEPTH - 1));
    single("first_word", 0, 0, 0, 1'b0, 1'b0, obs);
    single("key_hit", 3, 8, 14, 1'b0, 1'b0, obs);
    single("key_miss", 3, 9, 14, 1'b0, 1'b0, obs);
    single("key_flip", 3, 7, 1, 1'b1, 1'b1, obs);

    stream("burst", 64, 10, 14, 1'b0);
    stream("rand", 200, -1, -1, 1'b1);

    // Reset with two requests in flight: neither may come out afterwards.
    @(posedge clk); #1;
    set_req(1, 2, 3, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.pix_ready = 1'b0;
    @(posedge clk); #1;
    set_req(2, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pix_ready = 1'b1;
    #1;
    chk("midrst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("midrst_pix_data",  32'(bus.pix_data),  32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) begin
      @(posedge clk); #2;
      chk("midrst_late_output", 32'(bus.pix_valid), 32'd0);
    end
    single("post_rst", 5, 6, 7, 1'b0, 1'b1, obs);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
